direction_sequence_buffer: RTL and testbench
============================================

// Module: direction_sequence_buffer
// PURPOSE
//  Parametrised Simon Says sequence store. Holds up to MAX_LEN directions of DIR_W bits each.
//  Plays them back oldest-first with a valid/ready handshake to the LED/tone driver.
//  Checks player guesses against the stored sequence, one per guess_valid.
//  Sits between the random direction generator, the playback driver and the game controller FSM.
// PARAMETERS
//  DIR_W    2   bits per direction code (2 -> up/down/left/right)
//  MAX_LEN  16  maximum sequence length; must be >= 2
//  LEN_W    $clog2(MAX_LEN+1)  width of length/index fields (derived, do not override)
// PORTS
//  clock        in   1      rising-edge clock, single clock domain
//  reset        in   1      synchronous, active-high; clears all state
//  clear        in   1      empty the sequence (honoured in IDLE only)
//  append_valid in   1      append append_dir at the tail (honoured in IDLE only)
//  append_dir   in   DIR_W  direction to append
//  start_play   in   1      begin playback (honoured in IDLE only)
//  play_ready   in   1      downstream accepts play_dir this cycle
//  play_valid   out  1      play_dir is valid
//  play_dir     out  DIR_W  current playback direction
//  play_last    out  1      play_dir is the final element
//  start_check  in   1      begin guess checking (honoured in IDLE only)
//  guess_valid  in   1      player guess strobe (honoured in CHECK only)
//  guess_dir    in   DIR_W  player guess
//  match        out  1      1-cycle pulse: guess equalled the expected direction
//  mismatch     out  1      1-cycle pulse: guess was wrong; check aborted
//  round_done   out  1      1-cycle pulse: whole sequence guessed correctly
//  busy         out  1      state != IDLE
//  length       out  LEN_W  number of stored directions
//  full         out  1      length == MAX_LEN
// BEHAVIOUR
//  Reset: state=IDLE, length=0, index=0. play_valid, play_last, match, mismatch, round_done and busy are 0.
//  Storage: register array mem[0..MAX_LEN-1]. Contents are not cleared on reset. Only entries below length are ever read.
//  FSM states: IDLE, PLAY, CHECK.
//  IDLE, priority order:
//   1. clear: length <= 0.
//   2. start_play with length>0: index <= 0, go to PLAY.
//   3. start_check with length>0: index <= 0, go to CHECK.
//   4. append_valid with !full: mem[length] <= append_dir, length++.
//   Lower-priority requests in the same cycle are dropped.
//   Append when full is dropped; length holds at MAX_LEN.
//   start_play or start_check with length==0 is ignored; state stays IDLE.
//  PLAY:
//   play_valid=1 and play_dir=mem[index] are driven from registered state. They are valid the cycle after start_play.
//   play_last = (index == length-1).
//   A transfer happens when play_valid && play_ready. On transfer, index++.
//   A transfer with play_last=1 returns to IDLE; play_valid is 0 on the next cycle.
//   With play_ready low, play_dir holds stable.
//   All inputs other than reset and play_ready are ignored.
//  CHECK:
//   On guess_valid, compare guess_dir with mem[index]. The result pulse is registered and appears 1 cycle after the strobe.
//   Equal, not last: match=1, index++, stay in CHECK.
//   Equal and index==length-1: match=1 and round_done=1 in the same cycle, go to IDLE.
//   Not equal: mismatch=1, go to IDLE. length is unchanged; the controller decides whether to clear.
//   At most one guess is evaluated per cycle. Back-to-back guess_valid is legal.
//  Pulses: match, mismatch and round_done are high for exactly one cycle. They are never high while IDLE persists without a guess.
//  Width: index and length are LEN_W bits. index never exceeds length-1, so no wrap-around is possible.
//  Reset mid-operation: abort immediately. The next cycle shows reset values and length=0.
// TESTING
//  T1 reset, append 3,1,2 -> length=3, full=0, busy=0, all pulses 0.
//  T2 start_play, play_ready=1 -> play_dir 3,1,2 on consecutive cycles; play_last only with 2; busy drops after.
//  T3 play_ready toggled 1,0,0,1 -> play_dir held stable while ready low; no element skipped or repeated.
//  T4 start_check, guesses 3,1,2 -> match x3; round_done coincides with the third match; state IDLE.
//  T5 start_check, guesses 3,0 -> match, then mismatch one cycle after the 0; length still 3.
//  T6 MAX_LEN=4: append 5 times -> length=4, full=1, mem unchanged by the 5th append. Reset during PLAY -> play_valid=0, length=0 the next cycle.

Source files
------------

// File: rtl/direction_sequence_buffer.sv
// Simon Says direction store: appends directions in IDLE, plays them back
// oldest-first over valid/ready, and checks player guesses one per strobe.
module direction_sequence_buffer #(
    parameter int DIR_W   = 2,
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             append_valid,
    input  logic [DIR_W-1:0] append_dir,
    input  logic             start_play,
    input  logic             play_ready,
    output logic             play_valid,
    output logic [DIR_W-1:0] play_dir,
    output logic             play_last,
    input  logic             start_check,
    input  logic             guess_valid,
    input  logic [DIR_W-1:0] guess_dir,
    output logic             match,
    output logic             mismatch,
    output logic             round_done,
    output logic             busy,
    output logic [LEN_W-1:0] length,
    output logic             full
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_CHECK
    } state_t;

    state_t           state_q;
    logic [LEN_W-1:0] length_q;
    logic [LEN_W-1:0] index_q;
    logic             match_q;
    logic             mismatch_q;
    logic             round_done_q;
    logic [DIR_W-1:0] mem_q [MAX_LEN];

    logic [DIR_W-1:0] cur_dir;
    logic             at_last;
    logic             has_items;
    logic             is_full;
    logic             do_append;

    always_comb begin
        cur_dir   = mem_q[index_q[IDX_W-1:0]];
        at_last   = (index_q == length_q - LEN_W'(1));
        has_items = (length_q != '0);
        is_full   = (length_q == LEN_W'(MAX_LEN));
        // Append is the lowest-priority IDLE request; an ignored start (empty
        // sequence) does not block it.
        do_append = !reset && (state_q == S_IDLE) && !clear
                    && !(start_play && has_items)
                    && !(start_check && has_items)
                    && append_valid && !is_full;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            length_q     <= '0;
            index_q      <= '0;
            match_q      <= 1'b0;
            mismatch_q   <= 1'b0;
            round_done_q <= 1'b0;
        end else begin
            match_q      <= 1'b0;
            mismatch_q   <= 1'b0;
            round_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (clear) begin
                        length_q <= '0;
                    end else if (start_play && has_items) begin
                        index_q <= '0;
                        state_q <= S_PLAY;
                    end else if (start_check && has_items) begin
                        index_q <= '0;
                        state_q <= S_CHECK;
                    end else if (do_append) begin
                        length_q <= length_q + LEN_W'(1);
                    end
                end
                S_PLAY: begin
                    if (play_ready) begin
                        if (at_last) begin
                            index_q <= '0;
                            state_q <= S_IDLE;
                        end else begin
                            index_q <= index_q + LEN_W'(1);
                        end
                    end
                end
                S_CHECK: begin
                    if (guess_valid) begin
                        if (guess_dir == cur_dir) begin
                            match_q <= 1'b1;
                            if (at_last) begin
                                round_done_q <= 1'b1;
                                index_q      <= '0;
                                state_q      <= S_IDLE;
                            end else begin
                                index_q <= index_q + LEN_W'(1);
                            end
                        end else begin
                            mismatch_q <= 1'b1;
                            index_q    <= '0;
                            state_q    <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Storage is deliberately left unreset; only entries below length are read.
    always_ff @(posedge clock) begin
        if (do_append) begin
            mem_q[length_q[IDX_W-1:0]] <= append_dir;
        end
    end

    always_comb begin
        play_valid = (state_q == S_PLAY);
        play_dir   = cur_dir;
        play_last  = (state_q == S_PLAY) && at_last;
        match      = match_q;
        mismatch   = mismatch_q;
        round_done = round_done_q;
        busy       = (state_q != S_IDLE);
        length     = length_q;
        full       = is_full;
    end

endmodule

// File: tb/tb_direction_sequence_buffer.sv
// Table-driven bench for direction_sequence_buffer with MAX_LEN=4, plus
// hand-written reset-during-operation sequences.
module tb_direction_sequence_buffer;

    localparam int DIR_W   = 2;
    localparam int MAX_LEN = 4;
    localparam int LEN_W   = 3;

    logic             clock = 1'b0;
    logic             reset;
    logic             clear;
    logic             append_valid;
    logic [DIR_W-1:0] append_dir;
    logic             start_play;
    logic             play_ready;
    logic             play_valid;
    logic [DIR_W-1:0] play_dir;
    logic             play_last;
    logic             start_check;
    logic             guess_valid;
    logic [DIR_W-1:0] guess_dir;
    logic             match;
    logic             mismatch;
    logic             round_done;
    logic             busy;
    logic [LEN_W-1:0] length;
    logic             full;

    direction_sequence_buffer #(
        .DIR_W  (DIR_W),
        .MAX_LEN(MAX_LEN)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .clear       (clear),
        .append_valid(append_valid),
        .append_dir  (append_dir),
        .start_play  (start_play),
        .play_ready  (play_ready),
        .play_valid  (play_valid),
        .play_dir    (play_dir),
        .play_last   (play_last),
        .start_check (start_check),
        .guess_valid (guess_valid),
        .guess_dir   (guess_dir),
        .match       (match),
        .mismatch    (mismatch),
        .round_done  (round_done),
        .busy        (busy),
        .length      (length),
        .full        (full)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       clr;
        logic       app;
        logic [1:0] adir;
        logic       sp;
        logic       pr;
        logic       sc;
        logic       gv;
        logic [1:0] gdir;
    } ins_t;

    typedef struct packed {
        logic       pv;
        logic [1:0] pdir;
        logic       pl;
        logic       m;
        logic       mm;
        logic       rd;
        logic       busy;
        logic [2:0] len;
        logic       full;
    } outs_t;

    typedef struct {
        string name;
        ins_t  i;
        outs_t o;
    } vec_t;

    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic void add(input string name,
                                input int clr, input int app, input int adir,
                                input int sp, input int pr, input int sc,
                                input int gv, input int gdir,
                                input int pv, input int pdir, input int pl,
                                input int m, input int mm, input int rd,
                                input int bsy, input int len, input int fl);
        vec_t v;
        v.name   = name;
        v.i.clr  = 1'(clr);
        v.i.app  = 1'(app);
        v.i.adir = 2'(adir);
        v.i.sp   = 1'(sp);
        v.i.pr   = 1'(pr);
        v.i.sc   = 1'(sc);
        v.i.gv   = 1'(gv);
        v.i.gdir = 2'(gdir);
        v.o.pv   = 1'(pv);
        v.o.pdir = 2'(pdir);
        v.o.pl   = 1'(pl);
        v.o.m    = 1'(m);
        v.o.mm   = 1'(mm);
        v.o.rd   = 1'(rd);
        v.o.busy = 1'(bsy);
        v.o.len  = 3'(len);
        v.o.full = 1'(fl);
        tbl.push_back(v);
    endfunction

    function automatic outs_t mk_out(input int pv, input int pdir, input int bsy,
                                     input int len, input int fl);
        outs_t o;
        o      = '0;
        o.pv   = 1'(pv);
        o.pdir = 2'(pdir);
        o.busy = 1'(bsy);
        o.len  = 3'(len);
        o.full = 1'(fl);
        return o;
    endfunction

    task automatic step(input ins_t v);
        clear        = v.clr;
        append_valid = v.app;
        append_dir   = v.adir;
        start_play   = v.sp;
        play_ready   = v.pr;
        start_check  = v.sc;
        guess_valid  = v.gv;
        guess_dir    = v.gdir;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input outs_t exp_in);
        outs_t act;
        outs_t exp;
        exp      = exp_in;
        act.pv   = play_valid;
        act.pdir = play_dir;
        act.pl   = play_last;
        act.m    = match;
        act.mm   = mismatch;
        act.rd   = round_done;
        act.busy = busy;
        act.len  = length;
        act.full = full;
        // play_dir is only meaningful while play_valid is expected high
        if (!exp.pv) begin
            act.pdir = 2'b0;
            exp.pdir = 2'b0;
        end
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got pv=%b dir=%0d last=%b m=%b mm=%b rd=%b busy=%b len=%0d full=%b; want pv=%b dir=%0d last=%b m=%b mm=%b rd=%b busy=%b len=%0d full=%b",
                     name, act.pv, act.pdir, act.pl, act.m, act.mm, act.rd, act.busy, act.len, act.full,
                     exp.pv, exp.pdir, exp.pl, exp.m, exp.mm, exp.rd, exp.busy, exp.len, exp.full);
        end
    endtask

    initial begin
        ins_t idle;
        ins_t v;
        idle = '0;

        //   name           clr app ad sp pr sc gv gd | pv pd pl m mm rd bsy len full
        add("t1_app3",       0, 1, 3, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 1, 0);
        add("t1_app1",       0, 1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 2, 0);
        add("t1_app2",       0, 1, 2, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 3, 0);
        add("t1_idle",       0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 3, 0);
        add("t2_start",      0, 0, 0, 1, 0, 0, 0, 0,   1, 3, 0, 0, 0, 0, 1, 3, 0);
        add("t2_xfer3",      0, 0, 0, 0, 1, 0, 0, 0,   1, 1, 0, 0, 0, 0, 1, 3, 0);
        add("t2_xfer1",      0, 0, 0, 0, 1, 0, 0, 0,   1, 2, 1, 0, 0, 0, 1, 3, 0);
        add("t2_xfer2",      0, 0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 3, 0);
        add("t3_start",      0, 0, 0, 1, 0, 0, 0, 0,   1, 3, 0, 0, 0, 0, 1, 3, 0);
        add("t3_rdy1",       0, 0, 0, 0, 1, 0, 0, 0,   1, 1, 0, 0, 0, 0, 1, 3, 0);
        add("t3_rdy0_a",     0, 1, 0, 0, 0, 1, 0, 0,   1, 1, 0, 0, 0, 0, 1, 3, 0);
        add("t3_rdy0_b",     1, 0, 0, 0, 0, 0, 1, 1,   1, 1, 0, 0, 0, 0, 1, 3, 0);
        add("t3_rdy1_b",     0, 0, 0, 0, 1, 0, 0, 0,   1, 2, 1, 0, 0, 0, 1, 3, 0);
        add("t3_hold_last",  0, 0, 0, 0, 0, 0, 0, 0,   1, 2, 1, 0, 0, 0, 1, 3, 0);
        add("t3_done",       0, 0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 3, 0);
        add("t4_start",      0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 1, 3, 0);
        add("t4_g3",         0, 0, 0, 0, 0, 0, 1, 3,   0, 0, 0, 1, 0, 0, 1, 3, 0);
        add("t4_g1",         0, 0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 1, 0, 0, 1, 3, 0);
        add("t4_gap",        0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 3, 0);
        add("t4_g2_done",    0, 0, 0, 0, 0, 0, 1, 2,   0, 0, 0, 1, 0, 1, 0, 3, 0);
        add("t4_after",      0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 3, 0);
        add("t5_start",      0, 1, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 1, 3, 0);
        add("t5_g3",         0, 0, 0, 0, 0, 0, 1, 3,   0, 0, 0, 1, 0, 0, 1, 3, 0);
        add("t5_g0_wrong",   0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 1, 0, 0, 3, 0);
        add("t5_after",      0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 3, 0);
        add("idle_guess",    0, 0, 0, 0, 0, 0, 1, 3,   0, 0, 0, 0, 0, 0, 0, 3, 0);
        add("clear_wins",    1, 1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0);
        add("play_empty",    0, 0, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0);
        add("check_empty",   0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0);
        add("t6_a0",         0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 1, 0);
        add("t6_a1",         0, 1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 2, 0);
        add("t6_a2",         0, 1, 2, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 3, 0);
        add("t6_a3_full",    0, 1, 3, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 4, 1);
        add("t6_a5_drop",    0, 1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 4, 1);
        add("t6_play",       0, 1, 0, 1, 0, 1, 0, 0,   1, 0, 0, 0, 0, 0, 1, 4, 1);
        add("t6_p1",         0, 0, 0, 0, 1, 0, 0, 0,   1, 1, 0, 0, 0, 0, 1, 4, 1);
        add("t6_p2",         0, 0, 0, 0, 1, 0, 0, 0,   1, 2, 0, 0, 0, 0, 1, 4, 1);
        add("t6_p3_last",    0, 0, 0, 0, 1, 0, 0, 0,   1, 3, 1, 0, 0, 0, 1, 4, 1);
        add("t6_end",        0, 0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 4, 1);

        reset = 1'b1;
        step(idle);
        step(idle);
        check("reset", mk_out(0, 0, 0, 0, 0));
        reset = 1'b0;

        for (int k = 0; k < tbl.size(); k++) begin
            step(tbl[k].i);
            check(tbl[k].name, tbl[k].o);
        end

        // Reset while playing the full sequence
        v    = idle;
        v.sp = 1'b1;
        step(v);
        check("rst_play_pre", mk_out(1, 0, 1, 4, 1));
        reset = 1'b1;
        v     = idle;
        v.pr  = 1'b1;
        step(v);
        reset = 1'b0;
        check("rst_play", mk_out(0, 0, 0, 0, 0));

        // Reset while checking, with a correct guess in the same cycle
        v      = idle;
        v.app  = 1'b1;
        v.adir = 2'd2;
        step(v);
        check("rst_chk_app", mk_out(0, 0, 0, 1, 0));
        v    = idle;
        v.sc = 1'b1;
        step(v);
        check("rst_chk_pre", mk_out(0, 0, 1, 1, 0));
        reset  = 1'b1;
        v      = idle;
        v.gv   = 1'b1;
        v.gdir = 2'd2;
        step(v);
        reset = 1'b0;
        check("rst_chk", mk_out(0, 0, 0, 0, 0));
        step(idle);
        check("rst_chk_after", mk_out(0, 0, 0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
